// File: rtl/speed_sampler.sv
// Windowed speed sampler: captures pos1 every max(period,2) clocks, keeps a moving
// average over 2^AVG_LOG2 windows and flags a run of zero-count windows as a stall.
module speed_sampler #(
  parameter int CNT_W     = 16,
  parameter int PER_W     = 24,
  parameter int AVG_LOG2  = 2,
  parameter int STALL_LIM = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  input  logic [PER_W-1:0] period,
  input  logic [CNT_W-1:0] pos1,
  output logic             clear_pos1,
  output logic [CNT_W-1:0] raw_count,
  output logic [CNT_W-1:0] speed_avg,
  output logic             speed_valid,
  output logic             stalled
);

  localparam int                DEPTH     = 1 << AVG_LOG2;
  localparam int                SUM_W     = CNT_W + AVG_LOG2;
  localparam int                FILL_W    = AVG_LOG2 + 1;
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(DEPTH - 1);
  localparam logic [7:0]        STALL_TH  = 8'(STALL_LIM);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [PER_W-1:0]  timer_q, timer_d;
  logic              clear_pos1_q, clear_pos1_d;
  logic [CNT_W-1:0]  raw_count_q, raw_count_d;
  logic [CNT_W-1:0]  speed_avg_q, speed_avg_d;
  logic              speed_valid_q, speed_valid_d;
  logic              stalled_q, stalled_d;
  logic              samp_q, samp_d;
  logic [CNT_W-1:0]  hist_q [DEPTH];
  logic [CNT_W-1:0]  hist_d [DEPTH];
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [7:0]        stall_q, stall_d;

  // Periods of 0 and 1 are stretched to the minimum window of 2 clocks.
  function automatic logic [PER_W-1:0] win_len(input logic [PER_W-1:0] p);
    if (p < PER_W'(2)) begin
      win_len = PER_W'(2);
    end else begin
      win_len = p;
    end
  endfunction

  assign clear_pos1  = clear_pos1_q;
  assign raw_count   = raw_count_q;
  assign speed_avg   = speed_avg_q;
  assign speed_valid = speed_valid_q;
  assign stalled     = stalled_q;

  // Next-state logic: window timer, sample capture, averaging pipeline and stall run.
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    clear_pos1_d  = 1'b0;
    raw_count_d   = raw_count_q;
    speed_avg_d   = speed_avg_q;
    speed_valid_d = 1'b0;
    stalled_d     = stalled_q;
    samp_d        = 1'b0;
    sum_d         = sum_q;
    fill_d        = fill_q;
    stall_d       = stall_q;
    for (int i = 0; i < DEPTH; i++) begin
      hist_d[i] = hist_q[i];
    end

    if (!enable) begin
      state_d     = ST_IDLE;
      timer_d     = PER_W'(0);
      sum_d       = SUM_W'(0);
      speed_avg_d = CNT_W'(0);
      fill_d      = FILL_W'(0);
      stall_d     = 8'd0;
      stalled_d   = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        hist_d[i] = CNT_W'(0);
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          // The start pulse occupies one clock, so the full length lands on the timer here.
          state_d      = ST_FILL;
          timer_d      = win_len(period);
          clear_pos1_d = 1'b1;
        end
        ST_FILL, ST_RUN: begin
          if (timer_q == PER_W'(0)) begin
            timer_d     = win_len(period) - PER_W'(1);
            raw_count_d = pos1;
            samp_d      = 1'b1;
            if (pos1 == CNT_W'(0)) begin
              if (stall_q == 8'hFF) begin
                stall_d = stall_q;
              end else begin
                stall_d = stall_q + 8'd1;
              end
            end else begin
              stall_d = 8'd0;
            end
            stalled_d = (stall_d >= STALL_TH);
          end else begin
            timer_d = timer_q - PER_W'(1);
          end
          // Pre-decoded so the pulse lines up with the terminal cycle from a flop.
          clear_pos1_d = (timer_q == PER_W'(1));

          if (samp_q) begin
            hist_d[0] = raw_count_q;
            for (int i = 1; i < DEPTH; i++) begin
              hist_d[i] = hist_q[i-1];
            end
            sum_d       = sum_q + SUM_W'(raw_count_q) - SUM_W'(hist_q[DEPTH-1]);
            speed_avg_d = sum_d[SUM_W-1:AVG_LOG2];
            if (state_q == ST_RUN) begin
              speed_valid_d = 1'b1;
            end else if (fill_q == FILL_LAST) begin
              state_d       = ST_RUN;
              speed_valid_d = 1'b1;
            end else begin
              fill_d = fill_q + FILL_W'(1);
            end
          end else begin
            speed_valid_d = 1'b0;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      timer_q       <= PER_W'(0);
      clear_pos1_q  <= 1'b0;
      raw_count_q   <= CNT_W'(0);
      speed_avg_q   <= CNT_W'(0);
      speed_valid_q <= 1'b0;
      stalled_q     <= 1'b0;
      samp_q        <= 1'b0;
      sum_q         <= SUM_W'(0);
      fill_q        <= FILL_W'(0);
      stall_q       <= 8'd0;
      for (int i = 0; i < DEPTH; i++) begin
        hist_q[i] <= CNT_W'(0);
      end
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      clear_pos1_q  <= clear_pos1_d;
      raw_count_q   <= raw_count_d;
      speed_avg_q   <= speed_avg_d;
      speed_valid_q <= speed_valid_d;
      stalled_q     <= stalled_d;
      samp_q        <= samp_d;
      sum_q         <= sum_d;
      fill_q        <= fill_d;
      stall_q       <= stall_d;
      for (int i = 0; i < DEPTH; i++) begin
        hist_q[i] <= hist_d[i];
      end
    end
  end

endmodule

// File: tb/tb_speed_sampler.sv
// Bench for speed_sampler: emulates the position counter, predicts outputs from a
// cycle-numbered window model, and pins the model with hand-computed expectations.
module tb_speed_sampler;

  localparam int CNT_W     = 16;
  localparam int PER_W     = 24;
  localparam int AVG_LOG2  = 2;
  localparam int STALL_LIM = 3;
  localparam int DEPTH     = 4;

  logic             clk = 1'b0;
  logic             resetn;
  logic             enable;
  logic [PER_W-1:0] period;
  logic [CNT_W-1:0] pos1;
  logic             clear_pos1;
  logic [CNT_W-1:0] raw_count;
  logic [CNT_W-1:0] speed_avg;
  logic             speed_valid;
  logic             stalled;

  speed_sampler #(
    .CNT_W(CNT_W), .PER_W(PER_W), .AVG_LOG2(AVG_LOG2), .STALL_LIM(STALL_LIM)
  ) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .period(period), .pos1(pos1),
    .clear_pos1(clear_pos1), .raw_count(raw_count), .speed_avg(speed_avg),
    .speed_valid(speed_valid), .stalled(stalled)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int now = 0;

  // counter emulation
  int ctr = 0, s = 0, cnt = 0;
  bit ovr = 1'b0;

  // observations
  int clr_q[$];
  int val_q[$];
  int avg_q[$];
  int nclr = 0;

  // model
  bit     m_run;
  longint m_next;
  longint m_pend;
  int     m_hist[$];
  int     m_nsamp, m_zero;
  bit     e_clear, e_valid, e_stalled;
  int     e_raw, e_avg;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, now);
    end
  endtask

  function automatic bit edge_now(input int s_i, input int c, input int p);
    if (c == 0 || s_i < 1) return 1'b0;
    return ((longint'(s_i - 1) * c) % p) < c;
  endfunction

  function automatic int plen();
    return (period < 24'd2) ? 2 : int'(period);
  endfunction

  task automatic model_reset();
    m_run = 1'b0; m_pend = -1; m_next = -1;
    m_hist.delete(); m_nsamp = 0; m_zero = 0;
    e_clear = 1'b0; e_valid = 1'b0; e_stalled = 1'b0; e_raw = 0; e_avg = 0;
  endtask

  // Predicts the outputs of the cycle following the edge that ends cycle 'now'.
  task automatic model_edge();
    longint sum;
    int p;
    if (!resetn) begin
      model_reset();
      return;
    end
    p = plen();
    e_valid = 1'b0;
    if (!enable) begin
      m_run = 1'b0; e_clear = 1'b0; e_avg = 0; e_stalled = 1'b0;
      m_hist.delete(); m_nsamp = 0; m_zero = 0; m_pend = -1;
    end else if (!m_run) begin
      m_run   = 1'b1;
      e_clear = 1'b1;
      m_next  = now + 1 + p;
    end else begin
      if (m_pend == now) begin
        m_hist.push_front(e_raw);
        if (m_hist.size() > DEPTH) void'(m_hist.pop_back());
        sum = 0;
        foreach (m_hist[i]) sum += m_hist[i];
        e_avg = int'(sum / DEPTH);
        m_nsamp++;
        e_valid = (m_nsamp >= DEPTH);
        m_pend = -1;
      end
      if (now == m_next) begin
        e_raw     = int'(pos1);
        m_zero    = (pos1 == 16'd0) ? ((m_zero < 255) ? m_zero + 1 : 255) : 0;
        e_stalled = (m_zero >= STALL_LIM);
        m_next    = now + p;
        m_pend    = now + 1;
      end
      e_clear = (now + 1 == m_next);
    end
  endtask

  task automatic tick();
    bit clr;
    @(negedge clk);
    chk("clear_pos1", clear_pos1, e_clear);
    chk("raw_count", raw_count, e_raw);
    chk("speed_avg", speed_avg, e_avg);
    chk("speed_valid", speed_valid, e_valid);
    chk("stalled", stalled, e_stalled);
    clr = clear_pos1;
    if (clear_pos1) begin
      clr_q.push_back(now);
      nclr++;
    end
    if (speed_valid) begin
      val_q.push_back(now);
      avg_q.push_back(int'(speed_avg));
    end
    @(posedge clk);
    model_edge();
    now++;
    #1;
    if (clr) begin
      ctr = 0; s = 1;
    end else begin
      if (edge_now(s, cnt, plen())) ctr++;
      s++;
    end
    pos1 = ovr ? 16'hFFFF : ctr[CNT_W-1:0];
  endtask

  task automatic run_windows(input int n);
    int target, budget;
    target = nclr + n;
    budget = 0;
    while (nclr < target && budget < n * 400) begin
      tick();
      budget++;
    end
    chk("window_budget", (nclr >= target), 1);
  endtask

  int step_exp [5] = '{10, 12, 15, 17, 20};
  int st_exp   [6] = '{0, 0, 0, 1, 1, 0};
  int rc_exp   [6] = '{5, 0, 0, 0, 0, 7};
  int nxt_cnt  [6] = '{0, 0, 0, 0, 7, 7};
  int c0, c1, c2;

  initial begin
    resetn = 1'b0; enable = 1'b0; period = 24'd100; pos1 = 16'd0;
    model_reset();
    repeat (3) tick();
    resetn = 1'b1;
    repeat (3) tick();
    chk("reset_clear", clear_pos1, 0);
    chk("reset_raw", raw_count, 0);
    chk("reset_avg", speed_avg, 0);
    chk("reset_valid", speed_valid, 0);
    chk("reset_stalled", stalled, 0);

    // reset in the middle of a window
    enable = 1'b1; cnt = 10;
    repeat (50) tick();
    #2; resetn = 1'b0; model_reset(); #1;
    chk("async_clear", clear_pos1, 0);
    chk("async_raw", raw_count, 0);
    chk("async_avg", speed_avg, 0);
    chk("async_valid", speed_valid, 0);
    chk("async_stalled", stalled, 0);
    tick();
    resetn = 1'b1;
    tick();
    chk("restart_clear", clear_pos1, 1);

    // steady speed: 10 counts per 100-clock window
    clr_q.delete(); val_q.delete(); avg_q.delete();
    run_windows(5);
    repeat (2) tick();
    chk("steady_strobes", val_q.size(), 1);
    chk("steady_win1", clr_q[1] - clr_q[0], 100);
    chk("steady_win2", clr_q[2] - clr_q[1], 100);
    chk("steady_raw", raw_count, 10);
    if (val_q.size() > 0) begin
      chk("steady_latency", val_q[0] - clr_q[4], 2);
      chk("steady_avg", avg_q[0], 10);
    end

    // step change 10 -> 20 counts per window
    run_windows(1);
    cnt = 20; val_q.delete(); avg_q.delete();
    run_windows(4);
    repeat (2) tick();
    chk("step_strobes", avg_q.size(), 5);
    foreach (avg_q[i]) if (i < 5) chk("step_avg", avg_q[i], step_exp[i]);
    chk("step_raw", raw_count, 20);

    // stall detection with 20-clock windows
    enable = 1'b0;
    repeat (3) tick();
    period = 24'd20; cnt = 5; enable = 1'b1;
    run_windows(1);
    for (int i = 0; i < 6; i++) begin
      run_windows(1);
      chk("stall_level", stalled, st_exp[i]);
      chk("stall_raw", raw_count, rc_exp[i]);
      cnt = nxt_cnt[i];
    end

    // period 0 and 1 both give 2-clock windows with a strobe every window
    period = 24'd0;
    run_windows(2);
    clr_q.delete(); val_q.delete();
    repeat (10) tick();
    chk("p0_clears", clr_q.size(), 5);
    chk("p0_strobes", val_q.size(), 5);
    if (clr_q.size() > 1) chk("p0_spacing", clr_q[1] - clr_q[0], 2);
    period = 24'd1;
    run_windows(2);
    clr_q.delete(); val_q.delete();
    repeat (10) tick();
    chk("p1_clears", clr_q.size(), 5);
    chk("p1_strobes", val_q.size(), 5);

    // period change mid-window takes effect at the next reload
    period = 24'd100;
    run_windows(1);
    c0 = clr_q[$];
    repeat (40) tick();
    period = 24'd50;
    run_windows(1);
    c1 = clr_q[$];
    run_windows(1);
    c2 = clr_q[$];
    chk("perchg_cur", c1 - c0, 100);
    chk("perchg_next", c2 - c1, 50);

    // full-scale counts must not wrap the sum
    ovr = 1'b1; pos1 = 16'hFFFF;
    run_windows(4);
    repeat (2) tick();
    chk("max_raw", raw_count, 65535);
    if (avg_q.size() > 0) chk("max_avg", avg_q[$], 65535);

    // enable drop in T+1 suppresses the pending strobe
    ovr = 1'b0; period = 24'd20; cnt = 10;
    run_windows(2);
    enable = 1'b0; val_q.delete();
    tick();
    chk("drop_valid", speed_valid, 0);
    chk("drop_avg", speed_avg, 0);
    chk("drop_clear", clear_pos1, 0);
    chk("drop_raw_hold", raw_count, 10);
    tick();
    chk("drop_no_strobe", val_q.size(), 0);

    // re-enable: a fresh fill of four samples precedes the next strobe
    clr_q.delete(); val_q.delete(); avg_q.delete();
    enable = 1'b1;
    run_windows(5);
    repeat (2) tick();
    chk("refill_strobes", val_q.size(), 1);
    if (val_q.size() > 0) begin
      chk("refill_latency", val_q[0] - clr_q[4], 2);
      chk("refill_avg", avg_q[0], 10);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
